// File: rtl/opl_multimode_lookup.sv
// opl_multimode_lookup: output port lookup stage. Buffers ingress words in a
// small fall-through FIFO, rewrites the destination one-hot field in each
// packet header, drops malformed packets and keeps saturating packet counters.
// Optional feature macro: OPL_LOOPBACK_MODE_EN (mode 3 returns packets to src).
module opl_multimode_lookup #(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned NUM_PORTS          = 4,
  parameter int unsigned SRC_PORT_POS       = 16,
  parameter int unsigned DST_PORT_POS       = 24,
  parameter int unsigned FIFO_DEPTH_BITS    = 2,
  parameter int unsigned CNT_WIDTH          = 32
) (
  input  logic                             axi_aclk,
  input  logic                             axi_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                             s_axis_tvalid,
  input  logic                             s_axis_tlast,
  output logic                             s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  input  logic [1:0]                       mode,
  input  logic [2*NUM_PORTS-1:0]           cfg_dst,
  input  logic                             cnt_clear,
  output logic [CNT_WIDTH-1:0]             pkt_in_cnt,
  output logic [CNT_WIDTH-1:0]             pkt_out_cnt,
  output logic [CNT_WIDTH-1:0]             pkt_drop_cnt
);

  localparam int unsigned DW    = C_AXIS_DATA_WIDTH;
  localparam int unsigned SW    = C_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UW    = C_AXIS_TUSER_WIDTH;
  localparam int unsigned PW    = 2 * NUM_PORTS;
  localparam int unsigned AW    = FIFO_DEPTH_BITS;
  localparam int unsigned OW    = FIFO_DEPTH_BITS + 1;
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned WW    = DW + SW + UW + 1;

  // Even bits of the port field are the MAC ports.
  function automatic logic [PW-1:0] mac_mask_f();
    logic [PW-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) m[2*i] = 1'b1;
    return m;
  endfunction

  localparam logic [PW-1:0] MAC_MASK = mac_mask_f();

  typedef enum logic [1:0] {HEADER, IN_PACKET, DROP} state_t;

  state_t         state, state_nxt;
  logic [WW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [OW-1:0]  occ, occ_nxt;
  logic           wr_en, pop, empty, drop_evt;
  logic [WW-1:0]  head;
  logic [DW-1:0]  h_data;
  logic [SW-1:0]  h_strb;
  logic [UW-1:0]  h_user;
  logic           h_last;
  logic           hold_q;
  logic [1:0]     mode_q, eff_mode;
  logic [PW-1:0]  cfg_q, eff_cfg;
  logic [PW-1:0]  src, dst, mac_bit, pair_dst;
  logic           drop_hdr;

  assign wr_en  = s_axis_tvalid & s_axis_tready;
  assign empty  = (occ == '0);
  assign head   = mem[rd_ptr];
  assign h_last = head[0];
  assign h_user = head[UW:1];
  assign h_strb = head[UW+SW:UW+1];
  assign h_data = head[WW-1:UW+SW+1];

  // FIFO storage, no reset needed on the data array.
  always_ff @(posedge axi_aclk) begin
    if (wr_en) mem[wr_ptr] <= {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};
  end

  assign occ_nxt = occ + OW'(wr_en) - OW'(pop);

  // FIFO pointers, occupancy and registered ingress ready.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      occ           <= occ_nxt;
      s_axis_tready <= (occ_nxt < OW'(DEPTH - 1));
    end
  end

  // Mode/cfg are frozen once a header is visible but still waiting for egress.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      hold_q <= 1'b0;
      mode_q <= '0;
      cfg_q  <= '0;
    end else begin
      hold_q <= (state == HEADER) & ~empty & ~drop_hdr & ~m_axis_tready;
      if (!hold_q) begin
        mode_q <= mode;
        cfg_q  <= cfg_dst;
      end
    end
  end

  assign eff_mode = hold_q ? mode_q : mode;
  assign eff_cfg  = hold_q ? cfg_q  : cfg_dst;

  // Header classification and destination computation.
  always_comb begin
    src      = h_user[SRC_PORT_POS +: PW];
    drop_hdr = (|(src & (src - PW'(1)))) | ((eff_mode == 2'd2) & (eff_cfg == '0));
    mac_bit  = (src & MAC_MASK) | ((src & ~MAC_MASK) >> 1);
    pair_dst = (|(src & MAC_MASK)) ? (src << 1) : (src >> 1);
    case (eff_mode)
      2'd1:    dst = MAC_MASK & ~mac_bit;
      2'd2:    dst = eff_cfg;
`ifdef OPL_LOOPBACK_MODE_EN
      2'd3:    dst = src;
`endif
      default: dst = pair_dst;
    endcase
    if (src == '0) dst = PW'(1);
  end

  // State register.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) state <= HEADER;
    else             state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      HEADER: begin
        if (!empty) begin
          if (drop_hdr) begin
            if (!h_last) state_nxt = DROP;
          end else if (m_axis_tready && !h_last) begin
            state_nxt = IN_PACKET;
          end
        end
      end
      IN_PACKET: if (!empty && m_axis_tready && h_last) state_nxt = HEADER;
      DROP:      if (!empty && h_last) state_nxt = HEADER;
      default:   state_nxt = HEADER;
    endcase
  end

  // Egress outputs, FIFO pop and drop event.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tuser  = h_user;
    pop           = 1'b0;
    drop_evt      = 1'b0;
    case (state)
      HEADER: begin
        if (!empty) begin
          if (drop_hdr) begin
            pop      = 1'b1;
            drop_evt = h_last;
          end else begin
            m_axis_tvalid = 1'b1;
            m_axis_tuser[DST_PORT_POS +: PW] = dst;
            pop           = m_axis_tready;
          end
        end
      end
      IN_PACKET: begin
        m_axis_tvalid = ~empty;
        pop           = ~empty & m_axis_tready;
      end
      DROP: begin
        pop      = ~empty;
        drop_evt = ~empty & h_last;
      end
      default: ;
    endcase
  end

  assign m_axis_tdata = h_data;
  assign m_axis_tstrb = h_strb;
  assign m_axis_tlast = h_last;

  // Saturating packet counters; clear wins over a same-cycle increment.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      pkt_in_cnt   <= '0;
      pkt_out_cnt  <= '0;
      pkt_drop_cnt <= '0;
    end else if (cnt_clear) begin
      pkt_in_cnt   <= '0;
      pkt_out_cnt  <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      if (wr_en && s_axis_tlast && !(&pkt_in_cnt))
        pkt_in_cnt <= pkt_in_cnt + CNT_WIDTH'(1);
      if (m_axis_tvalid && m_axis_tready && h_last && !(&pkt_out_cnt))
        pkt_out_cnt <= pkt_out_cnt + CNT_WIDTH'(1);
      if (drop_evt && !(&pkt_drop_cnt))
        pkt_drop_cnt <= pkt_drop_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_opl_multimode_lookup.sv
// Bench for opl_multimode_lookup: directed steps plus randomized packets
// checked against a per-packet reference model and an egress scoreboard.
`timescale 1ns/1ps
module tb_opl_multimode_lookup;

  localparam int unsigned DW  = 256;
  localparam int unsigned SW  = 32;
  localparam int unsigned UW  = 128;
  localparam int unsigned NP  = 4;
  localparam int unsigned PW  = 8;
  localparam int unsigned CW  = 4;
  localparam int unsigned SRC = 16;
  localparam int unsigned DST = 24;
  localparam logic [CW-1:0] CMAX = '1;
`ifdef OPL_LOOPBACK_MODE_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
    logic          first;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [SW-1:0] s_tstrb = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic [UW-1:0] m_tuser;
  logic          m_valid;
  logic          m_tlast;
  logic          m_ready = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [PW-1:0] cfg_dst = '0;
  logic          cnt_clear = 1'b0;
  logic [CW-1:0] pkt_in_cnt, pkt_out_cnt, pkt_drop_cnt;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int occ = 0;
  bit occ_chk = 1'b0;
  bit saw_low = 1'b0;
  int hdr_in_cyc = 0;
  int first_out_cyc = 0;
  logic [UW-1:0] last_hdr_user = '0;

  word_t expq[$];
  bit in_pkt = 1'b0;
  bit cur_drop = 1'b0;
  logic [CW-1:0] exp_in = '0, exp_out = '0, exp_drop = '0;

  opl_multimode_lookup #(
    .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .NUM_PORTS(NP),
    .SRC_PORT_POS(SRC), .DST_PORT_POS(DST), .FIFO_DEPTH_BITS(2), .CNT_WIDTH(CW)
  ) dut (
    .axi_aclk(clk), .axi_resetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_ready),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_valid), .m_axis_tlast(m_tlast), .m_axis_tready(m_ready),
    .mode(mode), .cfg_dst(cfg_dst), .cnt_clear(cnt_clear),
    .pkt_in_cnt(pkt_in_cnt), .pkt_out_cnt(pkt_out_cnt), .pkt_drop_cnt(pkt_drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] x);
    return (x == CMAX) ? x : x + CW'(1);
  endfunction

  // Reference: destination from the port-numbering rules (index arithmetic).
  function automatic void model_hdr(input logic [UW-1:0] u, input logic [1:0] md,
                                    input logic [PW-1:0] cfg, output bit drop,
                                    output logic [UW-1:0] nu);
    logic [PW-1:0] s, d;
    int ones, idx;
    s = u[SRC +: PW];
    ones = 0;
    idx = 0;
    for (int i = 0; i < int'(PW); i++) if (s[i]) begin ones++; idx = i; end
    drop = (ones > 1) || (md == 2'd2 && cfg == 8'h00);
    if (md == 2'd2)                 d = cfg;
    else if (md == 2'd1)            d = 8'h55 & ~(8'h01 << (2 * (idx / 2)));
    else if (md == 2'd3 && LOOPBACK) d = s;
    else if (idx % 2 == 1)          d = 8'h01 << (idx - 1);
    else                            d = 8'h01 << (idx + 1);
    if (ones == 0) d = 8'h01;
    nu = u;
    nu[DST +: PW] = d;
  endfunction

  task automatic model_in(input word_t w, input bit clr);
    bit drop;
    logic [UW-1:0] nu;
    word_t e;
    e = w;
    e.first = 1'b0;
    if (!in_pkt) begin
      model_hdr(w.user, mode, cfg_dst, drop, nu);
      cur_drop = drop;
      e.user = nu;
      e.first = 1'b1;
      hdr_in_cyc = cyc;
    end
    if (!cur_drop) expq.push_back(e);
    in_pkt = !w.last;
    if (clr) begin exp_in = '0; exp_out = '0; exp_drop = '0; end
    if (w.last) begin
      if (!clr) exp_in = sat(exp_in);
      if (cur_drop) exp_drop = sat(exp_drop);
      else          exp_out = sat(exp_out);
    end
  endtask

  task automatic send_word(input logic [UW-1:0] u, input bit last, input bit clr);
    word_t w;
    int t;
    w.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    w.strb = $urandom;
    w.user = u;
    w.last = last;
    w.first = 1'b0;
    s_tdata = w.data; s_tstrb = w.strb; s_tuser = u; s_tlast = last; s_tvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 200) begin @(negedge clk); t++; end
    if (!s_ready) check("ingress_timeout", s_ready, 1);
    else begin
      if (clr) cnt_clear = 1'b1;
      model_in(w, clr);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    cnt_clear = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [PW-1:0] src, input bit gaps);
    logic [UW-1:0] u;
    for (int i = 0; i < n; i++) begin
      u = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0) u[SRC +: PW] = src;
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send_word(u, i == n - 1, 1'b0);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 2000) begin @(posedge clk); t++; end
    check("drain_timeout", expq.size(), 0);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_in_cnt"}, pkt_in_cnt, exp_in);
    check({tag, "_out_cnt"}, pkt_out_cnt, exp_out);
    check({tag, "_drop_cnt"}, pkt_drop_cnt, exp_drop);
  endtask

  // Egress ready pattern: 0 = always ready, 1 = random, 2 = toggling.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       m_ready = 1'($urandom_range(0, 1));
        2:       m_ready = ~m_ready;
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Egress scoreboard.
  always @(negedge clk) begin
    word_t e;
    if (rst_n && m_valid && m_ready) begin
      if (expq.size() == 0) check("egress_unexpected", expq.size(), 1);
      else begin
        e = expq.pop_front();
        check("egress_data", m_tdata, e.data);
        check("egress_strb", m_tstrb, e.strb);
        check("egress_user", m_tuser, e.user);
        check("egress_last", m_tlast, e.last);
        if (e.first) begin
          last_hdr_user = m_tuser;
          first_out_cyc = cyc;
        end
      end
    end
  end

  // Ingress ready against occupancy derived from observed handshakes.
  always @(negedge clk) begin
    if (occ_chk) begin
      check("ready_vs_occ", s_ready, occ < 3);
      if (!s_ready) saw_low = 1'b1;
      occ = occ + int'(s_tvalid && s_ready) - int'(m_valid && m_ready);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [UW-1:0] u;
    logic [PW-1:0] src;
    int a, b;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_valid, 0);
    check("rst_tready", s_ready, 0);
    check_cnts("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_tready", s_ready, 1);

    // Mode 0, MAC1 -> CPU1.
    mode = 2'd0;
    send_pkt(3, 8'h04, 1'b0);
    drain();
    check("m0_mac1_dst", last_hdr_user[DST +: PW], 8'h08);
    check("m0_in_cnt", pkt_in_cnt, 1);
    check("m0_out_cnt", pkt_out_cnt, 1);

    // Mode 1, CPU0 -> all MACs except MAC0; mode 0 src=0 -> MAC0.
    mode = 2'd1;
    send_pkt(2, 8'h02, 1'b0);
    drain();
    check("m1_cpu0_dst", last_hdr_user[DST +: PW], 8'h54);
    mode = 2'd0;
    send_pkt(1, 8'h00, 1'b0);
    drain();
    check("m0_src0_dst", last_hdr_user[DST +: PW], 8'h01);

    // Malformed source dropped, following packet forwarded promptly.
    send_pkt(4, 8'h05, 1'b0);
    send_pkt(2, 8'h01, 1'b0);
    drain();
    check("drop_cnt", pkt_drop_cnt, 1);
    check("no_bubble", (first_out_cyc - hdr_in_cyc) <= 2, 1);
    check("after_drop_dst", last_hdr_user[DST +: PW], 8'h02);
    check_cnts("drop");

    // Mode 2 with toggling egress ready and cfg change mid-packet.
    mode = 2'd2;
    cfg_dst = 8'h10;
    rdy_mode = 2;
    occ = 0;
    saw_low = 1'b0;
    occ_chk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      u = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0) u[SRC +: PW] = 8'h01;
      send_word(u, i == 9, 1'b0);
      if (i == 2) cfg_dst = 8'h20;
    end
    drain();
    occ_chk = 1'b0;
    rdy_mode = 0;
    check("m2_dst_latched", last_hdr_user[DST +: PW], 8'h10);
    check("ready_deasserted", saw_low, 1);
    check_cnts("m2");

    // Counter clear coinciding with an ingress tlast handshake.
    mode = 2'd0;
    u = {$urandom, $urandom, $urandom, $urandom};
    u[SRC +: PW] = 8'h01;
    send_word(u, 1'b1, 1'b1);
    drain();
    check("clr_in_cnt", pkt_in_cnt, 0);
    check_cnts("clr");

    // Mode 3 (loopback when enabled, else pairing).
    mode = 2'd3;
    send_pkt(2, 8'h40, 1'b0);
    drain();
    check("m3_dst", last_hdr_user[DST +: PW], LOOPBACK ? 8'h40 : 8'h80);

    // Randomized batches; counters saturate along the way.
    for (int bt = 0; bt < 6; bt++) begin
      mode = 2'($urandom_range(0, 3));
      cfg_dst = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rdy_mode = 1;
      for (int p = 0; p < 8; p++) begin
        case ($urandom_range(0, 5))
          0: src = 8'h00;
          1: begin
            a = $urandom_range(0, 7);
            b = (a + $urandom_range(1, 7)) % 8;
            src = (8'h01 << a) | (8'h01 << b);
          end
          default: src = 8'h01 << $urandom_range(0, 7);
        endcase
        send_pkt($urandom_range(1, 5), src, 1'b1);
      end
      drain();
      check_cnts("rand");
    end
    rdy_mode = 0;

    // Saturation with known traffic.
    mode = 2'd0;
    for (int p = 0; p < 16; p++) send_pkt(1, 8'h01, 1'b0);
    drain();
    check("sat_out_cnt", pkt_out_cnt, CMAX);
    check_cnts("sat");

    // Reset pulse mid-packet.
    mode = 2'd0;
    u = {$urandom, $urandom, $urandom, $urandom};
    u[SRC +: PW] = 8'h04;
    send_word(u, 1'b0, 1'b0);
    send_word({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", m_valid, 0);
    check("midrst_tready", s_ready, 0);
    expq.delete();
    in_pkt = 1'b0;
    exp_in = '0; exp_out = '0; exp_drop = '0;
    check_cnts("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_pkt(2, 8'h02, 1'b0);
    drain();
    check("post_rst_hdr_dst", last_hdr_user[DST +: PW], 8'h01);
    check_cnts("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
